// File: rtl/riscv_trace_buffer.sv
// Retire-trace capture buffer for the single-cycle RISC-V core.
// Each retired instruction is classified (REG / MEM / BR / NONE), stamped
// with a running retire count and pushed into a circular FIFO. A valid/ready
// port drains the FIFO toward a debug UART or DMA engine.
module riscv_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ret_valid,
  input  logic [31:0]                ret_pc,
  input  logic [31:0]                ret_instr,
  input  logic                       ret_reg_write,
  input  logic [4:0]                 ret_rd,
  input  logic [31:0]                ret_result,
  input  logic                       ret_mem_write,
  input  logic [31:0]                ret_mem_addr,
  input  logic [31:0]                ret_mem_data,
  input  logic                       ret_branch_taken,
  input  logic [31:0]                ret_pc_next,
  input  logic                       filt_none,
  output logic                       trc_valid,
  input  logic                       trc_ready,
  output logic [31:0]                trc_pc,
  output logic [31:0]                trc_instr,
  output logic [1:0]                 trc_kind,
  output logic [31:0]                trc_a,
  output logic [31:0]                trc_b,
  output logic [CYC_W-1:0]           trc_stamp,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_REG  = 2'd1,
    KIND_MEM  = 2'd2,
    KIND_BR   = 2'd3
  } kind_e;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    kind_e            kind;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [CYC_W-1:0] stamp;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CYC_W-1:0] ret_cnt;

  rec_t  rec_in;
  kind_e kind;
  logic  push;
  logic  pop;
  logic  full;
  logic  wr_en;
  logic  drop;

  // Classify the retiring instruction with fixed priority and build its record.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the priority chain can leave it unassigned and infer a latch.
    kind   = KIND_NONE;
    rec_in = '0;
    if (ret_reg_write && (ret_rd != 5'd0)) begin
      kind     = KIND_REG;
      rec_in.a = {27'd0, ret_rd};
      rec_in.b = ret_result;
    end else if (ret_mem_write) begin
      kind     = KIND_MEM;
      rec_in.a = ret_mem_addr;
      rec_in.b = ret_mem_data;
    end else if (ret_branch_taken) begin
      kind     = KIND_BR;
      rec_in.a = ret_pc_next;
    end
    rec_in.pc    = ret_pc;
    rec_in.instr = ret_instr;
    rec_in.kind  = kind;
    rec_in.stamp = ret_cnt;
  end

  // Handshake and accept/drop decisions; a full FIFO still accepts when the
  // head leaves in the same cycle.
  always_comb begin
    full  = (level == LW'(DEPTH));
    push  = ret_valid && !(filt_none && (kind == KIND_NONE));
    pop   = trc_valid && trc_ready;
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
  end

  // Pointers, occupancy, retire counter and drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      ret_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update in
      // this block sees the pre-edge values of its neighbours.
      if (ret_valid) ret_cnt <= ret_cnt + CYC_W'(1);
      if (wr_en)     wr_ptr  <= wr_ptr + AW'(1);
      if (pop)       rd_ptr  <= rd_ptr + AW'(1);
      if (wr_en && !pop)      level <= level + LW'(1);
      else if (pop && !wr_en) level <= level - LW'(1);
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents are meaningless until written
    // and the outputs are masked by trc_valid, so resetting it would only add
    // a reset net to every storage bit.
    if (wr_en) mem[wr_ptr] <= rec_in;
  end

  // Head entry drives the trace port; outputs read zero while empty. The head
  // slot is never overwritten while it is still being presented.
  always_comb begin
    trc_valid = (level != '0);
    trc_pc    = '0;
    trc_instr = '0;
    trc_kind  = '0;
    trc_a     = '0;
    trc_b     = '0;
    trc_stamp = '0;
    if (trc_valid) begin
      trc_pc    = mem[rd_ptr].pc;
      trc_instr = mem[rd_ptr].instr;
      trc_kind  = mem[rd_ptr].kind;
      trc_a     = mem[rd_ptr].a;
      trc_b     = mem[rd_ptr].b;
      trc_stamp = mem[rd_ptr].stamp;
    end
  end

endmodule
